// File: rtl/i_cache_nway_burst.sv
// rtl/i_cache_nway_burst.sv - N-way set-associative instruction cache with AXI burst-read refill
module i_cache_nway_burst #(
    parameter int WAYS       = 2,
    parameter int SETS       = 64,
    parameter int LINE_WORDS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_inst_req,
    input  logic        cpu_inst_wr,
    input  logic [1:0]  cpu_inst_size,
    input  logic [31:0] cpu_inst_addr,
    input  logic [31:0] cpu_inst_wdata,
    output logic [31:0] cpu_inst_rdata,
    output logic        cpu_inst_addr_ok,
    output logic        cpu_inst_data_ok,
    output logic [31:0] i_araddr,
    output logic [3:0]  i_arlen,
    output logic [2:0]  i_arsize,
    output logic        i_arvalid,
    input  logic        i_arready,
    input  logic [31:0] i_rdata,
    input  logic        i_rlast,
    input  logic        i_rvalid,
    output logic        i_rready
);
    localparam int OFF  = $clog2(LINE_WORDS);
    localparam int IDX  = $clog2(SETS);
    localparam int TAGW = 30 - OFF - IDX;
    localparam int WB   = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_MISS_AR, S_REFILL, S_RESP} state_t;

    state_t          r_state;
    logic [31:0]     r_addr;
    logic [TAGW-1:0] r_tag_ram  [WAYS][SETS];
    logic [31:0]     r_data_ram [WAYS][SETS*LINE_WORDS];
    logic [TAGW-1:0] r_tag_q    [WAYS];
    logic [31:0]     r_word_q   [WAYS];
    logic [WAYS-1:0] r_valid    [SETS];
    logic [WB-1:0]   r_rr       [SETS];
    logic [WB-1:0]   r_victim;
    logic            r_use_rr;
    logic            r_uncached;
    logic [OFF-1:0]  r_beat;
    logic [31:0]     r_ret;
    logic [31:0]     r_araddr;
    logic [3:0]      r_arlen;

    logic [OFF-1:0]  w_off;
    logic [IDX-1:0]  w_idx;
    logic [TAGW-1:0] w_tag;
    logic            w_unc;
    logic [IDX-1:0]  w_rd_idx;
    logic [OFF-1:0]  w_rd_off;
    logic            w_hit;
    logic [31:0]     w_hit_word;
    logic            w_lookup_hit;
    logic            w_has_inv;
    logic [WB-1:0]   w_inv_way;
    logic [WB-1:0]   w_victim;
    logic            w_beat;
    logic            w_fill_done;
    logic            w_unused;

    assign w_off = r_addr[OFF+1:2];
    assign w_idx = r_addr[OFF+IDX+1:OFF+2];
    assign w_tag = r_addr[31:OFF+IDX+2];
    assign w_unc = (r_addr[31:29] == 3'b101);

    // Arrays are addressed by the incoming request when it is accepted, otherwise by the held one
    assign w_rd_idx = cpu_inst_addr_ok ? cpu_inst_addr[OFF+IDX+1:OFF+2] : w_idx;
    assign w_rd_off = cpu_inst_addr_ok ? cpu_inst_addr[OFF+1:2] : w_off;

    assign w_beat      = (r_state == S_REFILL) && i_rvalid;
    assign w_fill_done = w_beat && i_rlast && !r_uncached && (r_beat == OFF'(LINE_WORDS - 1));

    assign w_unused = ^{cpu_inst_wr, cpu_inst_size, cpu_inst_wdata};

    // Tag compare across all ways; an uncached address never hits
    always_comb begin
        w_hit      = 1'b0;
        w_hit_word = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (r_valid[w_idx][w] && (r_tag_q[w] == w_tag)) begin
                w_hit      = 1'b1;
                w_hit_word = r_word_q[w];
            end
        end
        if (w_unc) begin
            w_hit = 1'b0;
        end
    end

    // Victim choice: lowest invalid way first, otherwise the set's round-robin pointer
    always_comb begin
        w_has_inv = 1'b0;
        w_inv_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!r_valid[w_idx][w]) begin
                w_has_inv = 1'b1;
                w_inv_way = WB'(w);
            end
        end
        w_victim = w_has_inv ? w_inv_way : r_rr[w_idx];
    end

    assign w_lookup_hit     = (r_state == S_LOOKUP) && w_hit;
    assign cpu_inst_addr_ok = cpu_inst_req && ((r_state == S_IDLE) || w_lookup_hit);
    assign cpu_inst_data_ok = w_lookup_hit || (r_state == S_RESP);
    assign cpu_inst_rdata   = w_lookup_hit ? w_hit_word : ((r_state == S_RESP) ? r_ret : 32'd0);

    assign i_araddr  = r_araddr;
    assign i_arlen   = r_arlen;
    assign i_arsize  = 3'b010;
    assign i_arvalid = (r_state == S_MISS_AR);
    assign i_rready  = (r_state == S_REFILL);

    // Tag array: synchronous read, written once the whole line has arrived
    always_ff @(posedge clk) begin
        for (int w = 0; w < WAYS; w++) begin
            r_tag_q[w] <= r_tag_ram[w][w_rd_idx];
        end
        if (!rst && w_fill_done) begin
            r_tag_ram[r_victim][w_idx] <= w_tag;
        end
    end

    // Data array: synchronous single-word read per way, refill beats written into the victim way
    always_ff @(posedge clk) begin
        for (int w = 0; w < WAYS; w++) begin
            r_word_q[w] <= r_data_ram[w][{w_rd_idx, w_rd_off}];
        end
        if (!rst && w_beat && !r_uncached) begin
            r_data_ram[r_victim][{w_idx, r_beat}] <= i_rdata;
        end
    end

    // Control FSM with valid bits, replacement pointers and the AXI request registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_victim   <= '0;
            r_use_rr   <= 1'b0;
            r_uncached <= 1'b0;
            r_beat     <= '0;
            r_ret      <= '0;
            r_araddr   <= '0;
            r_arlen    <= '0;
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                r_rr[s]    <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cpu_inst_addr_ok) begin
                        r_addr  <= cpu_inst_addr;
                        r_state <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (w_hit) begin
                        if (cpu_inst_req) begin
                            r_addr <= cpu_inst_addr;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_state    <= S_MISS_AR;
                        r_uncached <= w_unc;
                        r_victim   <= w_victim;
                        r_use_rr   <= !w_has_inv;
                        r_beat     <= '0;
                        if (w_unc) begin
                            r_araddr <= r_addr;
                            r_arlen  <= 4'd0;
                        end else begin
                            r_araddr <= {r_addr[31:OFF+2], {(OFF+2){1'b0}}};
                            r_arlen  <= 4'(LINE_WORDS - 1);
                            // Drop the victim now so a cut-short burst never leaves a stale-but-valid line
                            r_valid[w_idx][w_victim] <= 1'b0;
                        end
                    end
                end
                S_MISS_AR: begin
                    if (i_arready) begin
                        r_state <= S_REFILL;
                    end
                end
                S_REFILL: begin
                    if (i_rvalid) begin
                        r_beat <= r_beat + 1'b1;
                        if (r_uncached || (r_beat == w_off)) begin
                            r_ret <= i_rdata;
                        end
                        if (i_rlast) begin
                            r_state <= S_RESP;
                        end
                        if (w_fill_done) begin
                            r_valid[w_idx][r_victim] <= 1'b1;
                            if (r_use_rr) begin
                                r_rr[w_idx] <= (r_rr[w_idx] == WB'(WAYS - 1)) ? '0 : r_rr[w_idx] + 1'b1;
                            end
                        end
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule
